sequencer_tone_gen: RTL and testbench



---
 rtl/sequencer_tone_gen_if.sv | 39 +++
 rtl/sequencer_tone_gen.sv | 200 ++++++++++++++++++++
 tb/tb_sequencer_tone_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sequencer_tone_gen_if.sv
// Note-code input and tone/status output bundle for sequencer_tone_gen.
// Latency: wires only; all timing lives in the consumer of the slave modport.
// Backpressure: none; note_in is sampled every cycle and outputs are always valid.
//
// Signals:
//   note_in  - 4-bit note code (0 = OFF, 1..13 = lowC..highC, 14/15 invalid)
//   enable   - 1 allows tone generation, 0 forces idle
//   tone_out - square-wave audio bit
//   active   - high while a note is playing or releasing
//   cur_note - note currently sounding, 0 when idle
//   bad_code - one-cycle pulse on entry into an invalid code (14/15)
interface sequencer_tone_gen_if;
    logic [3:0] note_in;
    logic       enable;
    logic       tone_out;
    logic       active;
    logic [3:0] cur_note;
    logic       bad_code;

    // Note source side.
    modport master (
        output note_in,
        output enable,
        input  tone_out,
        input  active,
        input  cur_note,
        input  bad_code
    );

    // Tone generator side.
    modport slave (
        input  note_in,
        input  enable,
        output tone_out,
        output active,
        output cur_note,
        output bad_code
    );
endinterface

// File: rtl/sequencer_tone_gen.sv
// Converts sequencer note codes into a 1-bit square-wave tone with a release hold.
// Latency: every output is registered and reacts one clock after note_in/enable change.
// Backpressure: none; note_in is sampled every cycle and never stalled.
//
// Ports:
//   clk    - 10 kHz system clock
//   n_rst  - asynchronous active-low reset
//   tg     - sequencer_tone_gen_if.slave (note_in, enable in; tone_out, active,
//            cur_note, bad_code out)
// Parameters:
//   HOLD_CYCLES - cycles a note keeps sounding after the input returns to OFF (0 = none)
//   PERIOD_W    - width of the period counter (must hold 38)
// Build option:
//   TONE_DUTY25_EN - when defined, tone_out is high for floor(P/4) cycles per period
//                    instead of floor(P/2).
module sequencer_tone_gen #(
    parameter int HOLD_CYCLES = 2500,
    parameter int PERIOD_W    = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sequencer_tone_gen_if.slave   tg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES);

    // Full-period length in clock cycles for each playable code.
    function automatic logic [PERIOD_W-1:0] period_of(input logic [3:0] code);
        logic [PERIOD_W-1:0] p;
        case (code)
            4'd1:    p = PERIOD_W'(38);
            4'd2:    p = PERIOD_W'(36);
            4'd3:    p = PERIOD_W'(34);
            4'd4:    p = PERIOD_W'(32);
            4'd5:    p = PERIOD_W'(30);
            4'd6:    p = PERIOD_W'(29);
            4'd7:    p = PERIOD_W'(27);
            4'd8:    p = PERIOD_W'(26);
            4'd9:    p = PERIOD_W'(24);
            4'd10:   p = PERIOD_W'(23);
            4'd11:   p = PERIOD_W'(21);
            4'd12:   p = PERIOD_W'(20);
            4'd13:   p = PERIOD_W'(19);
            // Unplayable codes never reach the counter; any value is harmless.
            default: p = PERIOD_W'(1);
        endcase
        return p;
    endfunction

    // Number of high cycles at the start of each period.
    function automatic logic [PERIOD_W-1:0] high_len(input logic [PERIOD_W-1:0] p);
`ifdef TONE_DUTY25_EN
        return p >> 2;
`else
        return p >> 1;
`endif
    endfunction

    state_t              state_q;
    logic [3:0]          cur_note_q;
    logic [PERIOD_W-1:0] pcnt_q;
    logic [15:0]         hold_q;
    logic                tone_q;
    logic                active_q;
    logic                bad_q;
    logic                bad_prev_q;

    logic                note_valid;
    logic                note_bad;
    logic                note_change;
    logic [PERIOD_W-1:0] cur_period;
    logic [PERIOD_W-1:0] pcnt_adv;
    logic                tone_adv;

    assign note_valid  = (tg.note_in != 4'd0) && (tg.note_in <= 4'd13);
    assign note_bad    = (tg.note_in >= 4'd14);
    assign note_change = (tg.note_in != cur_note_q);

    // Free-running continuation of the current note's phase.
    always_comb begin
        cur_period = period_of(cur_note_q);
        pcnt_adv   = (pcnt_q == cur_period - PERIOD_W'(1)) ? '0 : pcnt_q + PERIOD_W'(1);
        tone_adv   = (pcnt_adv < high_len(cur_period));
    end

    // Note start/restart always lands on pcnt = 0, which is inside the high
    // phase for every playable period, so tone_out goes straight to 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cur_note_q <= 4'd0;
            pcnt_q     <= '0;
            hold_q     <= 16'd0;
            tone_q     <= 1'b0;
            active_q   <= 1'b0;
            bad_q      <= 1'b0;
            bad_prev_q <= 1'b0;
        end else begin
            // Edge-detected so a held 14/15 reports only once.
            bad_q      <= note_bad && !bad_prev_q;
            bad_prev_q <= note_bad;

            if (!tg.enable) begin
                state_q    <= IDLE;
                cur_note_q <= 4'd0;
                pcnt_q     <= '0;
                hold_q     <= 16'd0;
                tone_q     <= 1'b0;
                active_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (note_valid) begin
                            state_q    <= PLAY;
                            cur_note_q <= tg.note_in;
                            pcnt_q     <= '0;
                            tone_q     <= 1'b1;
                            active_q   <= 1'b1;
                        end
                    end

                    PLAY: begin
                        if (note_valid) begin
                            if (note_change) begin
                                cur_note_q <= tg.note_in;
                                pcnt_q     <= '0;
                                tone_q     <= 1'b1;
                            end else begin
                                pcnt_q <= pcnt_adv;
                                tone_q <= tone_adv;
                            end
                        end else if (HOLD_CYCLES == 0) begin
                            state_q    <= IDLE;
                            cur_note_q <= 4'd0;
                            pcnt_q     <= '0;
                            tone_q     <= 1'b0;
                            active_q   <= 1'b0;
                        end else begin
                            // OFF or invalid code: keep sounding for the hold time.
                            state_q <= RELEASE;
                            hold_q  <= HOLD_LOAD;
                            pcnt_q  <= pcnt_adv;
                            tone_q  <= tone_adv;
                        end
                    end

                    RELEASE: begin
                        // A valid note beats hold expiry on the same edge.
                        if (note_valid) begin
                            state_q <= PLAY;
                            hold_q  <= 16'd0;
                            if (note_change) begin
                                cur_note_q <= tg.note_in;
                                pcnt_q     <= '0;
                                tone_q     <= 1'b1;
                            end else begin
                                pcnt_q <= pcnt_adv;
                                tone_q <= tone_adv;
                            end
                        end else if (hold_q <= 16'd1) begin
                            // Counter would reach 0 on this edge: the release is over,
                            // giving exactly HOLD_CYCLES cycles in RELEASE.
                            state_q    <= IDLE;
                            hold_q     <= 16'd0;
                            cur_note_q <= 4'd0;
                            pcnt_q     <= '0;
                            tone_q     <= 1'b0;
                            active_q   <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 16'd1;
                            pcnt_q <= pcnt_adv;
                            tone_q <= tone_adv;
                        end
                    end

                    default: begin
                        state_q    <= IDLE;
                        cur_note_q <= 4'd0;
                        pcnt_q     <= '0;
                        hold_q     <= 16'd0;
                        tone_q     <= 1'b0;
                        active_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tg.tone_out = tone_q;
    assign tg.active   = active_q;
    assign tg.cur_note = cur_note_q;
    assign tg.bad_code = bad_q;

endmodule

// File: tb/tb_sequencer_tone_gen.sv
// Directed bench for sequencer_tone_gen with a 4-cycle release hold.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none; inputs are driven just after each rising edge.
module tb_sequencer_tone_gen;

    logic clk;
    logic n_rst;

    int vectors     = 0;
    int miscompares = 0;

    sequencer_tone_gen_if tg ();

    sequencer_tone_gen #(
        .HOLD_CYCLES (4),
        .PERIOD_W    (6)
    ) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .tg    (tg.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // High-phase length for a given period, matching the build's duty cycle.
    function automatic int thr(input int p);
`ifdef TONE_DUTY25_EN
        return p / 4;
`else
        return p / 2;
`endif
    endfunction

    // Expected tone at phase index k of a note with period p.
    function automatic logic exp_tone(input int k, input int p);
        return ((k % p) < thr(p)) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst         = 1'b1;
        tg.enable     = 1'b0;
        tg.note_in    = 4'd0;
        #2;
        n_rst = 1'b0;
        #10;
        chk("rst_tone",   {7'd0, tg.tone_out}, 8'd0);
        chk("rst_active", {7'd0, tg.active},   8'd0);
        chk("rst_cur",    {4'd0, tg.cur_note}, 8'd0);
        chk("rst_bad",    {7'd0, tg.bad_code}, 8'd0);

        // Hold code 10: period 23.
        @(posedge clk);
        #1;
        n_rst      = 1'b1;
        tg.enable  = 1'b1;
        tg.note_in = 4'd10;
        step();
        chk("c10_active", {7'd0, tg.active},   8'd1);
        chk("c10_cur",    {4'd0, tg.cur_note}, 8'd10);
        chk("c10_tone0",  {7'd0, tg.tone_out}, 8'd1);
        for (int k = 1; k < 46; k++) begin
            step();
            chk("c10_tone", {7'd0, tg.tone_out}, {7'd0, exp_tone(k, 23)});
        end

        // Code 1, then switch to 13 during the high phase: phase restarts.
        tg.note_in = 4'd1;
        step();
        chk("c1_cur",  {4'd0, tg.cur_note}, 8'd1);
        chk("c1_tone", {7'd0, tg.tone_out}, 8'd1);
        step();
        step();
        step();
        chk("c1_high", {7'd0, tg.tone_out}, 8'd1);
        tg.note_in = 4'd13;
        step();
        chk("c13_cur",   {4'd0, tg.cur_note}, 8'd13);
        chk("c13_tone0", {7'd0, tg.tone_out}, 8'd1);
        for (int k = 1; k < 38; k++) begin
            step();
            chk("c13_tone", {7'd0, tg.tone_out}, {7'd0, exp_tone(k, 19)});
        end

        // Code 5 then OFF: exactly 4 release cycles, then idle.
        tg.note_in = 4'd5;
        step();
        chk("c5_cur", {4'd0, tg.cur_note}, 8'd5);
        step();
        step();
        tg.note_in = 4'd0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rel_active", {7'd0, tg.active},   8'd1);
            chk("rel_cur",    {4'd0, tg.cur_note}, 8'd5);
            chk("rel_tone",   {7'd0, tg.tone_out}, {7'd0, exp_tone(2 + i, 30)});
        end
        step();
        chk("rel_end_active", {7'd0, tg.active},   8'd0);
        chk("rel_end_tone",   {7'd0, tg.tone_out}, 8'd0);
        chk("rel_end_cur",    {4'd0, tg.cur_note}, 8'd0);

        // Same note returns on the expiry edge: no IDLE cycle, no phase restart.
        tg.note_in = 4'd5;
        step();
        step();
        tg.note_in = 4'd0;
        step();
        step();
        step();
        step();
        chk("exp_rel_active", {7'd0, tg.active}, 8'd1);
        tg.note_in = 4'd5;
        step();
        chk("exp_active", {7'd0, tg.active},   8'd1);
        chk("exp_cur",    {4'd0, tg.cur_note}, 8'd5);
        chk("exp_tone6",  {7'd0, tg.tone_out}, {7'd0, exp_tone(6, 30)});
        for (int k = 7; k <= 16; k++) begin
            step();
            chk("exp_tone",   {7'd0, tg.tone_out}, {7'd0, exp_tone(k, 30)});
            chk("exp_active", {7'd0, tg.active},   8'd1);
        end

        // Invalid code from IDLE: single bad_code pulse, no activity.
        tg.enable = 1'b0;
        step();
        chk("dis_active", {7'd0, tg.active},   8'd0);
        chk("dis_tone",   {7'd0, tg.tone_out}, 8'd0);
        tg.enable  = 1'b1;
        tg.note_in = 4'd15;
        step();
        chk("bad_pulse",  {7'd0, tg.bad_code}, 8'd1);
        chk("bad_active", {7'd0, tg.active},   8'd0);
        step();
        chk("bad_held1", {7'd0, tg.bad_code}, 8'd0);
        step();
        chk("bad_held2",  {7'd0, tg.bad_code}, 8'd0);
        chk("bad_active", {7'd0, tg.active},   8'd0);
        tg.note_in = 4'd0;
        step();

        // Invalid code from PLAY behaves like OFF.
        tg.note_in = 4'd3;
        step();
        chk("c3_cur", {4'd0, tg.cur_note}, 8'd3);
        tg.note_in = 4'd14;
        step();
        chk("bad_play_pulse",  {7'd0, tg.bad_code}, 8'd1);
        chk("bad_play_active", {7'd0, tg.active},   8'd1);
        step();
        step();
        step();
        chk("bad_rel_active", {7'd0, tg.active}, 8'd1);
        step();
        chk("bad_rel_idle", {7'd0, tg.active}, 8'd0);
        tg.note_in = 4'd0;
        step();

        // Code 8 (period 26), enable drop, then asynchronous reset mid-tone.
        tg.note_in = 4'd8;
        step();
        chk("c8_cur",   {4'd0, tg.cur_note}, 8'd8);
        chk("c8_tone0", {7'd0, tg.tone_out}, 8'd1);
        for (int k = 1; k < 26; k++) begin
            step();
            chk("c8_tone", {7'd0, tg.tone_out}, {7'd0, exp_tone(k, 26)});
        end
        tg.enable = 1'b0;
        step();
        chk("en_off_active", {7'd0, tg.active},   8'd0);
        chk("en_off_tone",   {7'd0, tg.tone_out}, 8'd0);
        chk("en_off_cur",    {4'd0, tg.cur_note}, 8'd0);
        tg.enable = 1'b1;
        step();
        chk("c8_again", {7'd0, tg.active}, 8'd1);
        step();
        step();
        n_rst = 1'b0;
        #1;
        chk("arst_tone",   {7'd0, tg.tone_out}, 8'd0);
        chk("arst_active", {7'd0, tg.active},   8'd0);
        chk("arst_cur",    {4'd0, tg.cur_note}, 8'd0);
        chk("arst_bad",    {7'd0, tg.bad_code}, 8'd0);
        #10;
        n_rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
